// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N requesters.
// A winner is picked in IDLE, granted for one cycle, and its data is
// committed with a one-cycle ack pulse; GAP settle cycles follow each commit.
module rr_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   d,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     q,
    output logic [IDW-1:0]       owner,
    output logic                 busy
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_gnt;
    logic [N-1:0]       r_ack;
    logic [WIDTH-1:0]   r_q;
    logic [IDW-1:0]     r_owner;
    logic               r_busy;
    logic [IDW-1:0]     r_ptr;
    logic [CW-1:0]      r_cnt;

    state_t             w_state_nxt;
    logic [N-1:0]       w_gnt_nxt;
    logic [N-1:0]       w_ack_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [IDW-1:0]     w_owner_nxt;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [CW-1:0]      w_cnt_nxt;

    logic [N-1:0]       w_eff;
    logic               w_any;
    logic [IDW-1:0]     w_win;
    logic [N-1:0]       w_win_oh;
    logic [N-1:0]       w_own_oh;
    logic [N-1:0]       w_req_sh;
    logic               w_req_own;
    logic [WIDTH-1:0]   w_dsel;
    logic [IDW-1:0]     w_ptr_inc;

    // A requester being acked this cycle is masked so it cannot win again
    // before its ack has fallen.
    assign w_eff = req & ~r_ack;

    // Rotating first-set search starting at the priority pointer.
    always_comb begin
        logic [N-1:0] sh;
        int unsigned  idx;
        w_any = 1'b0;
        w_win = '0;
        sh    = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            sh  = w_eff >> idx;
            if (!w_any && sh[0]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    // Owner-indexed views of the inputs and the one-hot encodings.
    always_comb begin
        w_win_oh  = {{(N-1){1'b0}}, 1'b1} << w_win;
        w_own_oh  = {{(N-1){1'b0}}, 1'b1} << r_owner;
        w_req_sh  = req >> r_owner;
        w_req_own = w_req_sh[0];
        w_dsel    = WIDTH'(d >> (int'(r_owner) * WIDTH));
        w_ptr_inc = (r_owner == IDW'(N - 1)) ? '0 : r_owner + 1'b1;
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_q_nxt     = r_q;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_win_oh;
                    w_owner_nxt = w_win;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_req_own) begin
                    w_q_nxt   = w_dsel;
                    w_ack_nxt = w_own_oh;
                    w_ptr_nxt = w_ptr_inc;
                    if (GAP > 0) begin
                        w_cnt_nxt   = CW'(GAP - 1);
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_q     <= w_q_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: two instances (GAP=1 and GAP=0), each checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_rr_reg_arbiter;

    logic        clk = 1'b0;
    logic        r;
    logic [3:0]  req_s [2];
    logic [31:0] d_s   [2];
    logic [3:0]  gnt_o [2];
    logic [3:0]  ack_o [2];
    logic [7:0]  q_o   [2];
    logic [1:0]  own_o [2];
    logic        busy_o[2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: phase 0 = free, 1 = grant visible, 2..G+1 = settle cycles.
    int unsigned ph  [2];
    int unsigned mptr[2];
    int unsigned mown[2];
    logic [3:0]  mg  [2];
    logic [3:0]  ma  [2];
    logic [7:0]  mq  [2];

    always #5 clk = ~clk;

    rr_reg_arbiter #(.N(4), .WIDTH(8), .IDW(2), .GAP(1)) u_dut0 (
        .clk(clk), .r(r), .req(req_s[0]), .d(d_s[0]),
        .gnt(gnt_o[0]), .ack(ack_o[0]), .q(q_o[0]), .owner(own_o[0]), .busy(busy_o[0])
    );

    rr_reg_arbiter #(.N(4), .WIDTH(8), .IDW(2), .GAP(0)) u_dut1 (
        .clk(clk), .r(r), .req(req_s[1]), .d(d_s[1]),
        .gnt(gnt_o[1]), .ack(ack_o[1]), .q(q_o[1]), .owner(own_o[1]), .busy(busy_o[1])
    );

    function automatic int unsigned gapv(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        ph[k] = 0; mptr[k] = 0; mown[k] = 0; mg[k] = '0; ma[k] = '0; mq[k] = '0;
    endtask

    task automatic model_step(input int k);
        logic [3:0] eff;
        bit found;
        int unsigned idx;
        if (r) begin
            model_reset(k);
            return;
        end
        eff   = req_s[k] & ~ma[k];
        ma[k] = '0;
        mg[k] = '0;
        if (ph[k] == 0) begin
            found = 0;
            for (int j = 0; j < 4; j++) begin
                idx = (mptr[k] + j) % 4;
                if (!found && eff[idx]) begin
                    found   = 1;
                    mown[k] = idx;
                end
            end
            if (found) begin
                mg[k] = 4'b0001 << mown[k];
                ph[k] = 1;
            end
        end else if (ph[k] == 1) begin
            if (req_s[k][mown[k]]) begin
                mq[k]   = d_s[k][mown[k]*8 +: 8];
                ma[k]   = 4'b0001 << mown[k];
                mptr[k] = (mown[k] + 1) % 4;
                ph[k]   = (gapv(k) > 0) ? 2 : 0;
            end else begin
                ph[k] = 0;
            end
        end else begin
            ph[k] = (ph[k] == gapv(k) + 1) ? 0 : ph[k] + 1;
        end
    endtask

    // One clock: advance the model on the edge, then compare both DUTs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            check("gnt",   k, 32'(gnt_o[k]),  32'(mg[k]));
            check("ack",   k, 32'(ack_o[k]),  32'(ma[k]));
            check("q",     k, 32'(q_o[k]),    32'(mq[k]));
            check("owner", k, 32'(own_o[k]),  mown[k]);
            check("busy",  k, 32'(busy_o[k]), 32'(ph[k] != 0));
        end
    endtask

    task automatic drive_both(input logic [3:0] rq, input logic [31:0] dd);
        for (int k = 0; k < 2; k++) begin
            req_s[k] = rq;
            d_s[k]   = dd;
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset with all requests high.
        r = 1'b1;
        drive_both(4'b1111, 32'h13121110);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_gnt",   k, 32'(gnt_o[k]),  32'h0);
            check("rst_ack",   k, 32'(ack_o[k]),  32'h0);
            check("rst_q",     k, 32'(q_o[k]),    32'h0);
            check("rst_owner", k, 32'(own_o[k]),  32'h0);
            check("rst_busy",  k, 32'(busy_o[k]), 32'h0);
        end

        // Fairness on the GAP=1 instance: commits every 3 cycles, rotating.
        r = 1'b0;
        step();
        check("first_gnt", 0, 32'(gnt_o[0]), 32'h1);
        check("first_gnt", 1, 32'(gnt_o[1]), 32'h1);
        step();
        check("fair_q",   0, 32'(q_o[0]),   32'h10);
        check("fair_ack", 0, 32'(ack_o[0]), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            step();
            step();
            check("fair_gap_ack", 0, 32'(ack_o[0]), 32'h0);
            step();
            check("fair_q",   0, 32'(q_o[0]),   32'h10 + 32'(c % 4));
            check("fair_ack", 0, 32'(ack_o[0]), 32'h1 << (c % 4));
        end

        // Single write, GAP=1 latency.
        r = 1'b1;
        drive_both(4'b0000, 32'h0);
        step();
        r = 1'b0;
        drive_both(4'b0001, 32'h000000A5);
        step();
        check("sw_gnt",  0, 32'(gnt_o[0]),  32'h1);
        check("sw_busy", 0, 32'(busy_o[0]), 32'h1);
        step();
        check("sw_q",     0, 32'(q_o[0]),    32'hA5);
        check("sw_ack",   0, 32'(ack_o[0]),  32'h1);
        check("sw_owner", 0, 32'(own_o[0]),  32'h0);
        check("sw_busy2", 0, 32'(busy_o[0]), 32'h1);
        drive_both(4'b0000, 32'h000000A5);
        step();
        check("sw_idle_busy", 0, 32'(busy_o[0]), 32'h0);
        check("sw_idle_ack",  0, 32'(ack_o[0]),  32'h0);

        // Abort: requester 2 drops during GRANT; pointer stays at 1.
        drive_both(4'b0100, 32'h007700A5);
        step();
        check("ab_gnt", 0, 32'(gnt_o[0]), 32'h4);
        drive_both(4'b0000, 32'h007700A5);
        step();
        check("ab_gnt0", 0, 32'(gnt_o[0]),  32'h0);
        check("ab_ack",  0, 32'(ack_o[0]),  32'h0);
        check("ab_q",    0, 32'(q_o[0]),    32'hA5);
        check("ab_busy", 0, 32'(busy_o[0]), 32'h0);
        drive_both(4'b0011, 32'h007700A5);
        step();
        check("ab_ptr_gnt", 0, 32'(gnt_o[0]), 32'h2);

        // Reset while gnt=0010 is up.
        r = 1'b1;
        step();
        check("rg_gnt",   0, 32'(gnt_o[0]),  32'h0);
        check("rg_ack",   0, 32'(ack_o[0]),  32'h0);
        check("rg_q",     0, 32'(q_o[0]),    32'h0);
        check("rg_owner", 0, 32'(own_o[0]),  32'h0);
        check("rg_busy",  0, 32'(busy_o[0]), 32'h0);

        // Masking on the GAP=0 instance: requester 3 holds req through ack.
        r = 1'b0;
        drive_both(4'b1000, 32'h3C000000);
        step();
        check("mk_gnt", 1, 32'(gnt_o[1]), 32'h8);
        step();
        check("mk_ack", 1, 32'(ack_o[1]), 32'h8);
        check("mk_q",   1, 32'(q_o[1]),   32'h3C);
        step();
        check("mk_nognt", 1, 32'(gnt_o[1]), 32'h0);
        check("mk_noack", 1, 32'(ack_o[1]), 32'h0);
        step();
        check("mk_regnt", 1, 32'(gnt_o[1]), 32'h8);

        // Randomised traffic obeying the requester protocol, with rare resets.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(149, 0) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (ack_o[k][i]) begin
                        if ($urandom_range(1, 0) == 1) begin
                            req_s[k][i] = 1'b1;
                            d_s[k][i*8 +: 8] = 8'($urandom);
                        end else begin
                            req_s[k][i] = 1'b0;
                        end
                    end else if (req_s[k][i]) begin
                        if ($urandom_range(19, 0) == 0) req_s[k][i] = 1'b0;
                    end else if ($urandom_range(2, 0) == 0) begin
                        req_s[k][i] = 1'b1;
                        d_s[k][i*8 +: 8] = 8'($urandom);
                    end
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
